// File: rtl/nrf24_rx_cmd_filter.sv
// nrf24_rx_cmd_filter
// Debounces the raw nRF24 receive byte stream into a stable command byte.
// A byte is accepted only after CONFIRM_CNT consecutive identical receptions.
// A link watchdog drives SAFE_VAL once no byte has arrived for TIMEOUT_CYC cycles.
module nrf24_rx_cmd_filter #(
  parameter int          CONFIRM_CNT = 3,
  parameter int          TIMEOUT_CYC = 50_000_000,
  parameter logic [7:0]  SAFE_VAL    = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  cmd_val,
  output logic        cmd_update,
  output logic        link_ok,
  output logic        link_lost,
  output logic [15:0] rx_byte_cnt
);

  localparam int            TW   = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);
  localparam logic [3:0]    CMAX = 4'(CONFIRM_CNT);

  typedef enum logic [1:0] {S_LOST, S_ACQUIRE, S_LOCKED} state_t;

  state_t        r_state,      w_state;
  logic [7:0]    r_cand,       w_cand;
  logic [3:0]    r_match,      w_match;
  logic [TW-1:0] r_timer,      w_timer;
  logic [7:0]    r_cmd_val,    w_cmd_val;
  logic          r_cmd_update, w_cmd_update;
  logic          r_link_ok,    w_link_ok;
  logic          r_link_lost,  w_link_lost;
  logic [15:0]   r_byte_cnt,   w_byte_cnt;
  logic [3:0]    w_match_upd;
  logic          w_confirm;

  // State and output registers; reset discards every bit of progress at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_LOST;
      r_cand       <= 8'h00;
      r_match      <= 4'd0;
      r_timer      <= '0;
      r_cmd_val    <= SAFE_VAL;
      r_cmd_update <= 1'b0;
      r_link_ok    <= 1'b0;
      r_link_lost  <= 1'b0;
      r_byte_cnt   <= 16'h0000;
    end else begin
      r_state      <= w_state;
      r_cand       <= w_cand;
      r_match      <= w_match;
      r_timer      <= w_timer;
      r_cmd_val    <= w_cmd_val;
      r_cmd_update <= w_cmd_update;
      r_link_ok    <= w_link_ok;
      r_link_lost  <= w_link_lost;
      r_byte_cnt   <= w_byte_cnt;
    end
  end

  // Next-state: a strobe always beats the watchdog; expiry only when the line is idle.
  always_comb begin
    w_state      = r_state;
    w_cand       = r_cand;
    w_match      = r_match;
    w_timer      = r_timer;
    w_cmd_val    = r_cmd_val;
    w_cmd_update = 1'b0;
    w_link_lost  = 1'b0;
    w_byte_cnt   = r_byte_cnt;
    w_match_upd  = 4'd0;
    w_confirm    = 1'b0;

    if (rx_valid) begin
      w_byte_cnt = r_byte_cnt + 16'd1;
      w_timer    = '0;
      if ((rx_data == r_cand) && (r_match != 4'd0)) begin
        w_match_upd = (r_match >= CMAX) ? CMAX : (r_match + 4'd1);
      end else begin
        w_cand      = rx_data;
        w_match_upd = 4'd1;
      end
      w_match = w_match_upd;
      // Re-confirming the value already published while locked is silent.
      w_confirm = (w_match_upd == CMAX) &&
                  ((r_state != S_LOCKED) || (w_cand != r_cmd_val));
      if (w_confirm) begin
        w_cmd_val    = w_cand;
        w_cmd_update = 1'b1;
        w_state      = S_LOCKED;
      end else if (r_state == S_LOST) begin
        w_state = S_ACQUIRE;
      end
    end else if (r_state != S_LOST) begin
      if (r_timer == TMAX) begin
        w_state     = S_LOST;
        w_cmd_val   = SAFE_VAL;
        w_link_lost = 1'b1;
        w_cand      = 8'h00;
        w_match     = 4'd0;
        w_timer     = '0;
      end else begin
        w_timer = r_timer + 1'b1;
      end
    end

    w_link_ok = (w_state == S_LOCKED);
  end

  assign cmd_val     = r_cmd_val;
  assign cmd_update  = r_cmd_update;
  assign link_ok     = r_link_ok;
  assign link_lost   = r_link_lost;
  assign rx_byte_cnt = r_byte_cnt;

endmodule

// File: tb/tb_nrf24_rx_cmd_filter.sv
// Scoreboard bench for nrf24_rx_cmd_filter (CONFIRM_CNT=3, TIMEOUT_CYC=100, SAFE_VAL=0).
// Stimulus pushes the expected cmd_update/link_lost events; a monitor pops and compares them.
module tb_nrf24_rx_cmd_filter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  cmd_val;
  logic        cmd_update;
  logic        link_ok;
  logic        link_lost;
  logic [15:0] rx_byte_cnt;

  nrf24_rx_cmd_filter #(
    .CONFIRM_CNT(3),
    .TIMEOUT_CYC(100),
    .SAFE_VAL(8'h00)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .cmd_val(cmd_val),
    .cmd_update(cmd_update),
    .link_ok(link_ok),
    .link_lost(link_lost),
    .rx_byte_cnt(rx_byte_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_lost;
    logic [7:0] val;
    bit         lok;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: every pulse on cmd_update or link_lost must match the next queued event.
  always @(negedge clk) begin
    if (rst && (cmd_update || link_lost)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: update=%0b lost=%0b cmd_val=0x%0h, expected no pulse (cycle %0d)",
                 cmd_update, link_lost, cmd_val, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("evt_is_lost", int'(link_lost), int'(e.is_lost));
        chk("evt_is_update", int'(cmd_update), int'(!e.is_lost));
        chk("evt_cmd_val", int'(cmd_val), int'(e.val));
        chk("evt_link_ok", int'(link_ok), int'(e.lok));
        chk("evt_cycle", cyc, e.cyc);
      end
    end
  end

  // One strobe sampled on the next rising edge; called from posedge+1.
  task automatic strobe(input logic [7:0] d, input bit exp_upd);
    if (exp_upd) exp_q.push_back('{is_lost: 1'b0, val: d, lok: 1'b1, cyc: cyc + 1});
    rx_data  = d;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_static(input string tag, input logic [7:0] v, input bit lok, input int cnt);
    @(negedge clk);
    chk({tag, "_cmd_val"}, int'(cmd_val), int'(v));
    chk({tag, "_link_ok"}, int'(link_ok), int'(lok));
    chk({tag, "_byte_cnt"}, int'(rx_byte_cnt), cnt);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_cmd_val", int'(cmd_val), 0);
    chk("rst_cmd_update", int'(cmd_update), 0);
    chk("rst_link_ok", int'(link_ok), 0);
    chk("rst_link_lost", int'(link_lost), 0);
    chk("rst_byte_cnt", int'(rx_byte_cnt), 0);
    idle(2);
    rst = 1'b1;
    idle(2);

    // Acquire 5A with strobes ten cycles apart
    strobe(8'h5A, 0); idle(9);
    strobe(8'h5A, 0); idle(9);
    strobe(8'h5A, 1);
    chk_static("lock5a", 8'h5A, 1, 3);

    // Differing bytes: cmd_val held until 11 confirms
    strobe(8'h11, 0);
    strobe(8'h11, 0);
    strobe(8'h22, 0);
    strobe(8'h11, 0);
    strobe(8'h11, 0);
    chk_static("hold5a", 8'h5A, 1, 8);
    strobe(8'h11, 1);
    chk_static("lock11", 8'h11, 1, 9);

    // Saturated repeats of the published value stay silent
    for (int i = 0; i < 10; i++) strobe(8'h11, 0);
    chk_static("sat11", 8'h11, 1, 19);

    // Watchdog expiry after 100 idle cycles (chk_static consumed one idle edge)
    exp_q.push_back('{is_lost: 1'b1, val: 8'h00, lok: 1'b0, cyc: cyc + 99});
    idle(99);
    chk_static("lost", 8'h00, 0, 19);

    // Relock on A5
    strobe(8'hA5, 0);
    strobe(8'hA5, 0);
    strobe(8'hA5, 1);
    chk_static("lockA5", 8'hA5, 1, 22);

    // Strobe lands exactly on the expiry cycle: 99 idle edges then the strobe
    idle(98);
    strobe(8'hA5, 0);
    chk_static("expiry_race", 8'hA5, 1, 23);
    idle(5);
    chk_static("after_race", 8'hA5, 1, 23);

    // Asynchronous reset between the 2nd and 3rd strobe
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
    idle(1);
    strobe(8'h5A, 0); idle(9);
    strobe(8'h5A, 0); idle(4);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_cmd_val", int'(cmd_val), 0);
    chk("arst_cmd_update", int'(cmd_update), 0);
    chk("arst_link_ok", int'(link_ok), 0);
    chk("arst_link_lost", int'(link_lost), 0);
    chk("arst_byte_cnt", int'(rx_byte_cnt), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(1);
    strobe(8'h5A, 0);
    chk_static("post_rst", 8'h00, 0, 1);

    // Counter wrap: alternating data never confirms
    for (int i = 0; i < 65534; i++) strobe(8'(i & 1), 0);
    chk_static("cnt_max", 8'h00, 0, 16'hFFFF);
    strobe(8'h00, 0);
    chk_static("cnt_wrap", 8'h00, 0, 0);

    idle(3);
    chk("pending_events", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
